probe_queue: RTL and testbench

- Parameterised circular FIFO with show-ahead read, occupancy flags, flush, exposed head/tail pointers and random-access probe read/write port.
- Used as the rename-stage physical-register free list (INIT_CODE=1 preload) and as a generic ROB/issue-style queue elsewhere.
- Single clock domain.

---
 rtl/probe_queue_pkg.sv | 10 +
 rtl/probe_queue.sv | 88 ++++++++
 tb/tb_probe_queue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/probe_queue_pkg.sv
// Shared constants and helpers for probe_queue instances (free lists, ROB/issue queues).
package probe_queue_pkg;

  localparam int INIT_FREELIST = 1;

  function automatic int unsigned depthOf(input int unsigned addrWidth);
    return 32'd1 << addrWidth;
  endfunction

endpackage

// File: rtl/probe_queue.sv
// Circular show-ahead FIFO with occupancy flags, flush, exposed pointers and a
// random-access probe read/write port; optional free-list preload at reset.
module probe_queue
  import probe_queue_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int SHOW_DEBUG = 0,
  parameter int INIT_CODE  = 0,
  parameter     QUEUE_NAME = "QUEUE"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pushReq_IN,
  input  logic [DATA_WIDTH-1:0] data_IN,
  input  logic                  popReq_IN,
  output logic [DATA_WIDTH-1:0] data_OUT,
  output logic                  emptyFlag_OUT,
  output logic                  fullFlag_OUT,
  input  logic                  flush_IN,
  output logic [ADDR_WIDTH-1:0] curTail_OUT,
  output logic [ADDR_WIDTH-1:0] curHead_OUT,
  input  logic [ADDR_WIDTH-1:0] probeIdx_IN,
  output logic [DATA_WIDTH-1:0] probeData_OUT,
  input  logic                  probePushReq_IN,
  input  logic [DATA_WIDTH-1:0] probeData_IN
);

  localparam int unsigned           DEPTH     = depthOf(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   HALF_CNT  = (ADDR_WIDTH+1)'(DEPTH / 2);
  localparam logic [ADDR_WIDTH-1:0] HALF_PTR  = ADDR_WIDTH'(DEPTH / 2);
  localparam bit                    PRELOAD   = (INIT_CODE == INIT_FREELIST);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head, tail;
  logic [ADDR_WIDTH:0]   count;
  logic                  popOk, pushOk;

  // Debug tracing lives outside the synthesizable view; keep the knobs for drop-in compatibility.
  logic unusedDebugCfg;
  assign unusedDebugCfg = (SHOW_DEBUG != 0) | (|QUEUE_NAME);

  assign popOk  = popReq_IN && (count != '0);
  assign pushOk = pushReq_IN && ((count != DEPTH_CNT) || popOk);

  assign data_OUT      = (count != '0) ? mem[head] : '0;
  assign probeData_OUT = mem[probeIdx_IN];
  assign curHead_OUT   = head;
  assign curTail_OUT   = tail;
  assign emptyFlag_OUT = (count == '0);
  assign fullFlag_OUT  = (count == DEPTH_CNT);

  // Push write is issued after the probe write so it wins a same-slot collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (PRELOAD) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[i[ADDR_WIDTH-1:0]] <= DATA_WIDTH'(i);
        end
      end
    end else if (!flush_IN) begin
      if (probePushReq_IN) mem[probeIdx_IN] <= probeData_IN;
      if (pushOk)          mem[tail]        <= data_IN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= PRELOAD ? HALF_PTR : '0;
      tail  <= '0;
      count <= PRELOAD ? HALF_CNT : '0;
    end else if (flush_IN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pushOk) tail <= tail + 1'b1;
      if (popOk)  head <= head + 1'b1;
      case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_probe_queue.sv
// Scoreboard bench for probe_queue: a 4-entry empty-reset queue under directed and
// random traffic, plus a 64-entry free-list-preload instance.
module tb_probe_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: DATA_WIDTH=8, ADDR_WIDTH=2, INIT_CODE=0
  logic       rstA, pushA, popA, flushA, pwA, emptyA, fullA;
  logic [7:0] dInA, dOutA, pDinA, pDoutA;
  logic [1:0] tailA, headA, pIdxA;

  probe_queue #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SHOW_DEBUG(0), .INIT_CODE(0), .QUEUE_NAME("QA")) dutA (
    .clk(clk), .reset(rstA), .pushReq_IN(pushA), .data_IN(dInA), .popReq_IN(popA),
    .data_OUT(dOutA), .emptyFlag_OUT(emptyA), .fullFlag_OUT(fullA), .flush_IN(flushA),
    .curTail_OUT(tailA), .curHead_OUT(headA), .probeIdx_IN(pIdxA), .probeData_OUT(pDoutA),
    .probePushReq_IN(pwA), .probeData_IN(pDinA));

  // ---------------- DUT B: DATA_WIDTH=6, ADDR_WIDTH=6, INIT_CODE=1
  logic       rstB, pushB, popB, flushB, pwB, emptyB, fullB;
  logic [5:0] dInB, dOutB, pDinB, pDoutB, tailB, headB, pIdxB;

  probe_queue #(.DATA_WIDTH(6), .ADDR_WIDTH(6), .SHOW_DEBUG(0), .INIT_CODE(1), .QUEUE_NAME("FREELIST")) dutB (
    .clk(clk), .reset(rstB), .pushReq_IN(pushB), .data_IN(dInB), .popReq_IN(popB),
    .data_OUT(dOutB), .emptyFlag_OUT(emptyB), .fullFlag_OUT(fullB), .flush_IN(flushB),
    .curTail_OUT(tailB), .curHead_OUT(headB), .probeIdx_IN(pIdxB), .probeData_OUT(pDoutB),
    .probePushReq_IN(pwB), .probeData_IN(pDinB));

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model for A: slot array, head index, occupancy count
  localparam int DA = 4;
  int  mm[DA];
  bit  known[DA];
  int  mHead = 0, mCount = 0;
  bit  mValid = 1'b0;

  typedef struct {
    bit valid;
    bit empty;
    bit full;
    int head;
    int tail;
    int dout;
    bit pKnown;
    int pval;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] popQ[$];
  logic [5:0] popQB[$];

  task automatic cyc(bit rst, bit fl, bit pu, logic [7:0] d, bit po, logic [1:0] pi, bit pw, logic [7:0] pd);
    exp_t e;
    bit   popOk, pushOk;
    @(negedge clk);
    rstA = rst; flushA = fl; pushA = pu; dInA = d; popA = po; pIdxA = pi; pwA = pw; pDinA = pd;
    e.valid  = mValid;
    e.empty  = (mCount == 0);
    e.full   = (mCount == DA);
    e.head   = mHead;
    e.tail   = (mHead + mCount) % DA;
    e.dout   = (mCount != 0) ? mm[mHead] : 0;
    e.pKnown = known[pi];
    e.pval   = mm[pi];
    expQ.push_back(e);
    popOk  = mValid && !rst && !fl && po && (mCount != 0);
    pushOk = mValid && !rst && !fl && pu && ((mCount < DA) || popOk);
    if (popOk) popQ.push_back(8'(mm[mHead]));
    if (rst || (mValid && fl)) begin
      mValid = 1'b1;
      mHead  = 0;
      mCount = 0;
    end else if (mValid) begin
      if (pw) begin mm[pi] = int'(pd); known[pi] = 1'b1; end
      if (pushOk) begin
        mm[(mHead + mCount) % DA]    = int'(d);
        known[(mHead + mCount) % DA] = 1'b1;
      end
      if (popOk) begin mHead = (mHead + 1) % DA; mCount--; end
      if (pushOk) mCount++;
    end
  endtask

  task automatic idleA(logic [1:0] pi);
    cyc(0, 0, 0, 8'h00, 0, pi, 0, 8'h00);
    #3;
  endtask

  // ---------------- monitors
  always @(negedge clk) begin : monA
    exp_t e;
    #2;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      if (e.valid) begin
        chk("a_empty", 32'(emptyA), 32'(e.empty));
        chk("a_full",  32'(fullA),  32'(e.full));
        chk("a_head",  32'(headA),  32'(e.head));
        chk("a_tail",  32'(tailA),  32'(e.tail));
        chk("a_dout",  32'(dOutA),  32'(e.dout));
        if (e.pKnown) chk("a_probe", 32'(pDoutA), 32'(e.pval));
      end
    end
    if (popA && !emptyA && !rstA && !flushA) begin
      if (popQ.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_pop_unexpected actual=%0h required=none @%0t", dOutA, $time);
      end else chk("a_pop", 32'(dOutA), 32'(popQ.pop_front()));
    end
  end

  always @(negedge clk) begin : monB
    #2;
    if (popB && !emptyB && !rstB && !flushB) begin
      if (popQB.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_pop_unexpected actual=%0h required=none @%0t", dOutB, $time);
      end else chk("b_pop", 32'(dOutB), 32'(popQB.pop_front()));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rstA = 1; pushA = 0; popA = 0; flushA = 0; pwA = 0; dInA = '0; pDinA = '0; pIdxA = '0;
    rstB = 1; pushB = 0; popB = 0; flushB = 0; pwB = 0; dInB = '0; pDinB = '0; pIdxB = '0;
    for (int i = 0; i < DA; i++) begin mm[i] = 0; known[i] = 1'b0; end

    // ---- A: reset state
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    idleA(0);
    chk("a_rst_empty", 32'(emptyA), 1); chk("a_rst_full", 32'(fullA), 0);
    chk("a_rst_head",  32'(headA), 0);  chk("a_rst_tail", 32'(tailA), 0);
    chk("a_rst_dout",  32'(dOutA), 0);

    // ---- fill, overflow push dropped
    for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 8'hA0 + 8'(i), 0, 0, 0, 8'h00);
    idleA(0);
    chk("a_full_flag", 32'(fullA), 1); chk("a_full_tail", 32'(tailA), 0);
    chk("a_full_dout", 32'(dOutA), 32'hA1);

    // ---- push+pop while full
    cyc(0, 0, 1, 8'hB0, 1, 0, 0, 8'h00);
    idleA(0);
    chk("a_pp_full", 32'(fullA), 1); chk("a_pp_head", 32'(headA), 1);
    chk("a_pp_tail", 32'(tailA), 1); chk("a_pp_mem0", 32'(pDoutA), 32'hB0);

    // ---- drain: A2, A3, A4, B0
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
    idleA(0);
    chk("a_drain_empty", 32'(emptyA), 1); chk("a_drain_dout", 32'(dOutA), 0);

    // ---- push+pop while empty: pop ignored
    cyc(0, 0, 1, 8'h3D, 1, 0, 0, 8'h00);
    idleA(0);
    chk("a_ep_empty", 32'(emptyA), 0); chk("a_ep_dout", 32'(dOutA), 32'h3D);
    chk("a_ep_tail", 32'(tailA), 2);

    // ---- probe write into occupied head slot
    cyc(0, 0, 1, 8'h4E, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 1, 1, 8'h5C);
    idleA(1);
    chk("a_probe_rd", 32'(pDoutA), 32'h5C); chk("a_probe_dout", 32'(dOutA), 32'h5C);
    chk("a_probe_head", 32'(headA), 1);     chk("a_probe_tail", 32'(tailA), 3);

    // ---- flush overrides push/pop/probe write
    cyc(0, 1, 1, 8'h77, 1, 2, 1, 8'h99);
    idleA(0);
    chk("a_flush_empty", 32'(emptyA), 1); chk("a_flush_head", 32'(headA), 0);
    chk("a_flush_tail", 32'(tailA), 0);

    // ---- randomized traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 45),
          2'($urandom), ($urandom_range(0, 99) < 15), 8'($urandom));
    end
    idleA(0);
    @(negedge clk); #4;
    chk("a_popq_drained", 32'(popQ.size()), 0);

    // ---- B: free-list preload
    @(negedge clk); rstB = 1;
    @(negedge clk); rstB = 1;
    @(negedge clk); rstB = 0;
    #3;
    chk("b_rst_head", 32'(headB), 32); chk("b_rst_tail", 32'(tailB), 0);
    chk("b_rst_dout", 32'(dOutB), 32); chk("b_rst_empty", 32'(emptyB), 0);
    chk("b_rst_full", 32'(fullB), 0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); popB = 1; popQB.push_back(6'(32 + i));
    end
    @(negedge clk); popB = 0;
    #3;
    chk("b_drain_empty", 32'(emptyB), 1); chk("b_drain_head", 32'(headB), 0);
    @(negedge clk); pushB = 1; dInB = 6'd5;
    @(negedge clk); pushB = 0;
    #3;
    chk("b_push_dout", 32'(dOutB), 5); chk("b_push_empty", 32'(emptyB), 0);
    chk("b_push_tail", 32'(tailB), 1);
    @(negedge clk); #4;
    chk("b_popq_drained", 32'(popQB.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
